// File: rtl/mpu_reg_arbiter.sv
// Arbitrates the vector register-file port between the load and store units.
// Alternates on ties and forces a release when a holder overstays HOLD_MAX cycles.
module mpu_reg_arbiter #(
  parameter int unsigned HOLD_MAX = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_req_in,
  input  logic load_done_in,
  input  logic store_req_in,
  input  logic store_done_in,
  input  logic err_clr_in,
  output logic load_ready_out,
  output logic store_ready_out,
  output logic reg_sel_out,
  output logic reg_busy_out,
  output logic arb_timeout_out
);

  localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic LG_LOAD  = 1'b0;
  localparam logic LG_STORE = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE        = 2'd0,
    ARB_GRANT_LOAD  = 2'd1,
    ARB_GRANT_STORE = 2'd2,
    ARB_RELEASE     = 2'd3
  } arb_state_e;

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             timeout_q, timeout_d;
  logic             timeout_set_s;
  logic             load_ready_q, store_ready_q, reg_sel_q, reg_busy_q;

  // Next-state, hold counter, tie-break memory and sticky timeout flag.
  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    last_grant_d  = last_grant_q;
    timeout_set_s = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        hold_cnt_d = {CNT_W{1'b0}};
        if (load_req_in && store_req_in) begin
          if (last_grant_q == LG_STORE) begin
            state_d      = ARB_GRANT_LOAD;
            last_grant_d = LG_LOAD;
          end else begin
            state_d      = ARB_GRANT_STORE;
            last_grant_d = LG_STORE;
          end
        end else if (load_req_in) begin
          state_d      = ARB_GRANT_LOAD;
          last_grant_d = LG_LOAD;
        end else if (store_req_in) begin
          state_d      = ARB_GRANT_STORE;
          last_grant_d = LG_STORE;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_GRANT_LOAD, ARB_GRANT_STORE: begin
        // Done from the holder beats a coincident timeout.
        if ((state_q == ARB_GRANT_LOAD) ? load_done_in : store_done_in) begin
          state_d = ARB_RELEASE;
        end else if (hold_cnt_q == CNT_LAST) begin
          state_d       = ARB_RELEASE;
          timeout_set_s = 1'b1;
        end else if (hold_cnt_q != CNT_SAT) begin
          hold_cnt_d = hold_cnt_q + CNT_ONE;
        end else begin
          hold_cnt_d = hold_cnt_q;
        end
      end
      ARB_RELEASE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    if (timeout_set_s) begin
      timeout_d = 1'b1;
    end else if (err_clr_in) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q;
    end
  end

  // State and output registers; outputs are decoded from the next state so they track state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ARB_IDLE;
      hold_cnt_q    <= {CNT_W{1'b0}};
      last_grant_q  <= LG_STORE;
      timeout_q     <= 1'b0;
      load_ready_q  <= 1'b0;
      store_ready_q <= 1'b0;
      reg_sel_q     <= 1'b0;
      reg_busy_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      last_grant_q  <= last_grant_d;
      timeout_q     <= timeout_d;
      load_ready_q  <= (state_d == ARB_GRANT_LOAD);
      store_ready_q <= (state_d == ARB_GRANT_STORE);
      reg_sel_q     <= (state_d == ARB_GRANT_STORE);
      reg_busy_q    <= (state_d == ARB_GRANT_LOAD) || (state_d == ARB_GRANT_STORE);
    end
  end

  assign load_ready_out  = load_ready_q;
  assign store_ready_out = store_ready_q;
  assign reg_sel_out     = reg_sel_q;
  assign reg_busy_out    = reg_busy_q;
  assign arb_timeout_out = timeout_q;

endmodule

// File: tb/tb_mpu_reg_arbiter.sv
// Scoreboard bench for mpu_reg_arbiter: one instance at the default HOLD_MAX,
// one at HOLD_MAX = 8 for the forced-release scenarios, sharing the same inputs.
module tb_mpu_reg_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic load_req_in, load_done_in, store_req_in, store_done_in, err_clr_in;
  logic l64, s64, sel64, b64, t64;
  logic l8, s8, sel8, b8, t8;
  logic [4:0] out64, out8;

  assign out64 = {l64, s64, sel64, b64, t64};
  assign out8  = {l8, s8, sel8, b8, t8};

  mpu_reg_arbiter dut64 (
    .clk(clk), .rst_n(rst_n),
    .load_req_in(load_req_in), .load_done_in(load_done_in),
    .store_req_in(store_req_in), .store_done_in(store_done_in),
    .err_clr_in(err_clr_in),
    .load_ready_out(l64), .store_ready_out(s64), .reg_sel_out(sel64),
    .reg_busy_out(b64), .arb_timeout_out(t64)
  );

  mpu_reg_arbiter #(.HOLD_MAX(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .load_req_in(load_req_in), .load_done_in(load_done_in),
    .store_req_in(store_req_in), .store_done_in(store_done_in),
    .err_clr_in(err_clr_in),
    .load_ready_out(l8), .store_ready_out(s8), .reg_sel_out(sel8),
    .reg_busy_out(b8), .arb_timeout_out(t8)
  );

  // Stimulus bits {load_req, load_done, store_req, store_done, err_clr}
  localparam logic [4:0] S_0  = 5'b00000;
  localparam logic [4:0] S_LR = 5'b10000;
  localparam logic [4:0] S_LD = 5'b01000;
  localparam logic [4:0] S_SR = 5'b00100;
  localparam logic [4:0] S_SD = 5'b00010;
  localparam logic [4:0] S_CL = 5'b00001;
  // Expected outputs {load_ready, store_ready, reg_sel, reg_busy, timeout}
  localparam logic [4:0] E_0 = 5'b00000;
  localparam logic [4:0] E_L = 5'b10010;
  localparam logic [4:0] E_S = 5'b01110;
  localparam logic [4:0] E_T = 5'b00001;

  int checks = 0;
  int errors = 0;
  logic [4:0] stim_q[$];
  logic [4:0] plan_q[$];
  logic [4:0] sb_q[$];
  logic [4:0] exp_v, got_v;

  task automatic add(input logic [4:0] s, input logic [4:0] e);
    stim_q.push_back(s);
    plan_q.push_back(e);
  endtask

  task automatic drive(input logic [4:0] s);
    {load_req_in, load_done_in, store_req_in, store_done_in, err_clr_in} = s;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(S_0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(S_0);
    #1;
    checks++;
    if (out64 !== E_0 || out8 !== E_0) begin
      errors++;
      $display("FAIL reset_initial: got %b/%b expected %b", out64, out8, E_0);
    end
    drive(S_LR | S_SR);
    @(posedge clk); #1;
    checks++;
    if (out64 !== E_0 || out8 !== E_0) begin
      errors++;
      $display("FAIL reset_held: got %b/%b expected %b", out64, out8, E_0);
    end
    rst_n = 1'b1;
    drive(S_LR);
    @(posedge clk); #1;
    checks++;
    if (out64 !== E_L || out8 !== E_L) begin
      errors++;
      $display("FAIL reset_first_req: got %b/%b expected %b", out64, out8, E_L);
    end
    drive(S_0);
  endtask

  task automatic test_load_only();
    int step = 0;
    do_reset();
    add(S_LR, E_L);
    for (int i = 1; i < 10; i++) add((i == 3) ? S_SD : S_0, E_L);
    add(S_LD, E_0);
    add(S_LR, E_0);
    add(S_LR, E_L);
    add(S_LD, E_0);
    add(S_LD, E_0);
    add(S_LD, E_0);
    add(S_SR, E_S);
    add(S_SD, E_0);
    add(S_0,  E_0);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      sb_q.push_back(plan_q.pop_front());
      @(posedge clk); #1;
      exp_v = sb_q.pop_front();
      got_v = out64;
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL load_only step %0d: got %b expected %b", step, got_v, exp_v);
      end
      step++;
    end
  endtask

  task automatic test_tie();
    int step = 0;
    do_reset();
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 5; k++) add(S_LR | S_SR, (g % 2 == 0) ? E_L : E_S);
      add(S_LR | S_SR | ((g % 2 == 0) ? S_LD : S_SD), E_0);
      add(S_LR | S_SR, E_0);
    end
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      sb_q.push_back(plan_q.pop_front());
      @(posedge clk); #1;
      exp_v = sb_q.pop_front();
      got_v = out64;
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL tie step %0d: got %b expected %b", step, got_v, exp_v);
      end
      checks++;
      if ((got_v[4] & got_v[3]) !== 1'b0) begin
        errors++;
        $display("FAIL tie_exclusive step %0d: got both ready %b expected 0", step, got_v);
      end
      step++;
    end
    drive(S_0);
  endtask

  task automatic test_timeout();
    int step = 0;
    do_reset();
    add(S_SR, E_S);
    for (int i = 0; i < 7; i++) add(S_0, E_S);
    add(S_0, E_T);
    for (int i = 0; i < 3; i++) add(S_0, E_T);
    add(S_CL, E_0);
    add(S_0,  E_0);
    add(S_SR, E_S);
    for (int i = 0; i < 7; i++) add(S_0, E_S);
    add(S_CL, E_T);
    add(S_0,  E_T);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      sb_q.push_back(plan_q.pop_front());
      @(posedge clk); #1;
      exp_v = sb_q.pop_front();
      got_v = out8;
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL timeout step %0d: got %b expected %b", step, got_v, exp_v);
      end
      step++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out8 !== E_0) begin
      errors++;
      $display("FAIL timeout_reset_clear: got %b expected %b", out8, E_0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_done_timeout();
    int step = 0;
    do_reset();
    add(S_LR, E_L);
    for (int i = 0; i < 7; i++) add(S_0, E_L);
    add(S_LD, E_0);
    add(S_0,  E_0);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      sb_q.push_back(plan_q.pop_front());
      @(posedge clk); #1;
      exp_v = sb_q.pop_front();
      got_v = out8;
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL done_timeout step %0d: got %b expected %b", step, got_v, exp_v);
      end
      step++;
    end
  endtask

  task automatic test_reset_mid_grant();
    int step = 0;
    do_reset();
    add(S_LR, E_L);
    add(S_LR, E_L);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      sb_q.push_back(plan_q.pop_front());
      @(posedge clk); #1;
      exp_v = sb_q.pop_front();
      got_v = out64;
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL mid_reset_pre step %0d: got %b expected %b", step, got_v, exp_v);
      end
      step++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out64 !== E_0) begin
      errors++;
      $display("FAIL mid_reset_async: got %b expected %b", out64, E_0);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    checks++;
    if (out64 !== E_0) begin
      errors++;
      $display("FAIL mid_reset_held: got %b expected %b", out64, E_0);
    end
    @(posedge clk); #1;
    checks++;
    if (out64 !== E_L) begin
      errors++;
      $display("FAIL mid_reset_regrant: got %b expected %b", out64, E_L);
    end
    drive(S_0);
  endtask

  initial begin
    test_reset();
    test_load_only();
    test_tie();
    test_timeout();
    test_done_timeout();
    test_reset_mid_grant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
